// File: rtl/ifetch_fault_reporter.sv
// Registers the fetch guard's fault into a one-entry trap request with valid/ready handshake.
// Optional saturating fault counter is enabled by defining IFETCH_FAULT_CNT_EN.
module ifetch_fault_reporter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fault_i,
    input  logic [31:0]      cause_i,
    input  logic [31:0]      tval_i,
    input  logic             flush_i,
    output logic             trap_valid_o,
    input  logic             trap_ready_i,
    output logic [31:0]      trap_cause_o,
    output logic [31:0]      trap_tval_o,
    output logic             fe_stall_o,
    output logic             overrun_o,
    output logic [CNT_W-1:0] fault_cnt_o,
    input  logic             cnt_clr_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        capture, overrun_set;
    logic        valid_q, stall_q, overrun_q;
    logic [31:0] cause_q, tval_q;

    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        overrun_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (fault_i && !flush_i) begin
                    capture = 1'b1;
                    state_d = PENDING;
                end
            end
            PENDING: begin
                // Handshake takes priority over a concurrent flush.
                if (trap_ready_i)
                    state_d = DRAIN;
                else if (flush_i)
                    state_d = IDLE;
                overrun_set = fault_i && !trap_ready_i && (tval_i != tval_q);
            end
            DRAIN: begin
                if (!fault_i || flush_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            stall_q   <= 1'b0;
            cause_q   <= '0;
            tval_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d == PENDING);
            stall_q <= (state_d != IDLE);
            if (capture) begin
                cause_q <= cause_i;
                tval_q  <= tval_i;
            end
            if (overrun_set)
                overrun_q <= 1'b1;
            else if (cnt_clr_i)
                overrun_q <= 1'b0;
        end
    end

`ifdef IFETCH_FAULT_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (cnt_clr_i)
            cnt_q <= capture ? CNT_W'(1) : '0;
        else if (capture && (cnt_q != '1))
            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign fault_cnt_o = cnt_q;
`else
    assign fault_cnt_o = '0;
`endif

    assign trap_valid_o = valid_q;
    assign trap_cause_o = cause_q;
    assign trap_tval_o  = tval_q;
    assign fe_stall_o   = stall_q;
    assign overrun_o    = overrun_q;

endmodule
